// File: rtl/sub_bytes_sched_pkg.sv
// sub_bytes_sched_pkg
//   Shared definitions for the SubBytes / SubWord scheduler:
//   - FSM state encoding (IDLE, RUN_S, RUN_K)
//   - last-grant encoding used for round-robin tie breaking
//   - AES width constants (byte, word, state)
//   - job lengths in bytes (16 for a state, 4 for a key word)
package sub_bytes_sched_pkg;

  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 32;
  localparam int STATE_W = 128;
  localparam int IDX_W   = 4;

  localparam int LEN_S = 16;
  localparam int LEN_K = 4;

  // Index of the final byte of each job type.
  localparam logic [IDX_W-1:0] LAST_S = IDX_W'(LEN_S - 1);
  localparam logic [1:0]       LAST_K = 2'(LEN_K - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN_S = 2'd1,
    ST_RUN_K = 2'd2
  } state_e;

  typedef enum logic {
    LG_S = 1'b0,
    LG_K = 1'b1
  } last_grant_e;

endpackage

// File: rtl/sub_bytes_sched_sbox.sv
// sbox
//   Combinational AES forward S-box (FIPS-197).
//   Ports:
//     a : input  byte
//     c : output substituted byte
//   The table is stored MSB-first: entry 0 occupies bits [2047:2040], so the
//   entry for input a starts at bit ((255 - a) * 8) = {~a, 3'b000}.
module sbox
  import sub_bytes_sched_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  output logic [BYTE_W-1:0] c
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign c = SBOX_TABLE[{~a, 3'b000} +: BYTE_W];

endmodule

// File: rtl/sub_bytes_sched.sv
// sub_bytes_sched
//   Time-multiplexes one S-box between two requesters: the cipher state path
//   (SubBytes over 16 bytes) and the key schedule path (SubWord over 4 bytes).
//   One byte is substituted per clock.
//
//   Ports:
//     clk, rst         clock; asynchronous active-high reset
//     req_s, din_s     state job request (level) and 128-bit state
//     req_k, din_k     key job request (level) and 32-bit word
//     gnt_s, gnt_k     one-cycle grant pulse: din was captured
//     done_s, done_k   one-cycle completion pulse
//     res_s, res_k     result registers (hold last completed value)
//     busy             FSM not idle
//     dbg_state        current FSM state encoding
//
//   Handshake: a requester raises req with stable din and keeps both until it
//   sees gnt for one cycle; din is captured on the edge that produces gnt, so
//   req may drop any time after gnt. Requests seen while busy are ignored, and
//   a req still high when the FSM returns to IDLE is granted again. Ties in
//   IDLE go to the requester not served last.
module sub_bytes_sched
  import sub_bytes_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req_s,
  input  logic [STATE_W-1:0]  din_s,
  input  logic                req_k,
  input  logic [WORD_W-1:0]   din_k,
  output logic                gnt_s,
  output logic                gnt_k,
  output logic                done_s,
  output logic                done_k,
  output logic [STATE_W-1:0]  res_s,
  output logic [WORD_W-1:0]   res_k,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  state_e               state_q, state_d;
  last_grant_e          lg_q, lg_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [STATE_W-1:0]   data_q, data_d;
  logic [STATE_W-1:0]   res_s_q, res_s_d;
  logic [WORD_W-1:0]    res_k_q, res_k_d;
  logic                 gnt_s_q, gnt_s_d;
  logic                 gnt_k_q, gnt_k_d;
  logic                 done_s_q, done_s_d;
  logic                 done_k_q, done_k_d;

  logic [BYTE_W-1:0]    sbox_in;
  logic [BYTE_W-1:0]    sbox_out;

  sbox u_sbox (
    .a (sbox_in),
    .c (sbox_out)
  );

  // Byte 0 is the most significant byte. A key word is captured into the low
  // 32 bits of the shared data buffer.
  always_comb begin
    sbox_in = '0;
    case (state_q)
      ST_RUN_S: sbox_in = data_q[{LAST_S - idx_q, 3'b000} +: BYTE_W];
      ST_RUN_K: sbox_in = data_q[{LAST_K - idx_q[1:0], 3'b000} +: BYTE_W];
      default:  sbox_in = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    lg_d     = lg_q;
    idx_d    = idx_q;
    data_d   = data_q;
    res_s_d  = res_s_q;
    res_k_d  = res_k_q;
    gnt_s_d  = 1'b0;
    gnt_k_d  = 1'b0;
    done_s_d = 1'b0;
    done_k_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // S wins when alone, or on a tie when K was served last.
        if (req_s && (!req_k || lg_q == LG_K)) begin
          state_d = ST_RUN_S;
          data_d  = din_s;
          idx_d   = '0;
          lg_d    = LG_S;
          gnt_s_d = 1'b1;
        end else if (req_k) begin
          state_d = ST_RUN_K;
          data_d  = {{(STATE_W - WORD_W){1'b0}}, din_k};
          idx_d   = '0;
          lg_d    = LG_K;
          gnt_k_d = 1'b1;
        end
      end

      ST_RUN_S: begin
        res_s_d[{LAST_S - idx_q, 3'b000} +: BYTE_W] = sbox_out;
        if (idx_q == LAST_S) begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          done_s_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_RUN_K: begin
        res_k_d[{LAST_K - idx_q[1:0], 3'b000} +: BYTE_W] = sbox_out;
        if (idx_q[1:0] == LAST_K) begin
          state_d  = ST_IDLE;
          idx_d    = '0;
          done_k_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      lg_q     <= LG_K;
      idx_q    <= '0;
      data_q   <= '0;
      res_s_q  <= '0;
      res_k_q  <= '0;
      gnt_s_q  <= 1'b0;
      gnt_k_q  <= 1'b0;
      done_s_q <= 1'b0;
      done_k_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lg_q     <= lg_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      res_s_q  <= res_s_d;
      res_k_q  <= res_k_d;
      gnt_s_q  <= gnt_s_d;
      gnt_k_q  <= gnt_k_d;
      done_s_q <= done_s_d;
      done_k_q <= done_k_d;
    end
  end

  assign gnt_s     = gnt_s_q;
  assign gnt_k     = gnt_k_q;
  assign done_s    = done_s_q;
  assign done_k    = done_k_q;
  assign res_s     = res_s_q;
  assign res_k     = res_k_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sub_bytes_sched.sv
// tb_sub_bytes_sched
//   Directed bench for sub_bytes_sched: reset values, single S and K jobs,
//   arbitration ties, ignored requests while busy, reset mid-job, and a full
//   S-box sweep through the K path against a GF(2^8) reference model.
module tb_sub_bytes_sched;

  logic         clk;
  logic         rst;
  logic         req_s;
  logic [127:0] din_s;
  logic         req_k;
  logic [31:0]  din_k;
  logic         gnt_s, gnt_k, done_s, done_k, busy;
  logic [127:0] res_s;
  logic [31:0]  res_k;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int excl_viol = 0;
  int done_s_total = 0;

  localparam logic [127:0] A_DIN = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] A_RES = 128'h638293c31bfc33f5c4eeacea4bc12816;
  localparam logic [31:0]  B_DIN = 32'h09cf4f3c;
  localparam logic [31:0]  B_RES = 32'h018a84eb;

  sub_bytes_sched dut (
    .clk       (clk),
    .rst       (rst),
    .req_s     (req_s),
    .din_s     (din_s),
    .req_k     (req_k),
    .din_k     (din_k),
    .gnt_s     (gnt_s),
    .gnt_k     (gnt_k),
    .done_s    (done_s),
    .done_k    (done_k),
    .res_s     (res_s),
    .res_k     (res_k),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Exclusivity of pulses and a global done_s pulse count.
  always @(negedge clk) begin
    if ((done_s && done_k) || (gnt_s && gnt_k)) excl_viol++;
    if (done_s) done_s_total++;
  end

  // reference model
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = x; bb = y;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
        {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  // checking
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_s(input logic [127:0] d, output int glat);
    glat = -1;
    req_s = 1'b1;
    din_s = d;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (gnt_s) begin glat = i; break; end
    end
    req_s = 1'b0;
  endtask

  task automatic start_k(input logic [31:0] d, output int glat);
    glat = -1;
    req_k = 1'b1;
    din_k = d;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (gnt_k) begin glat = i; break; end
    end
    req_k = 1'b0;
  endtask

  task automatic wait_done_s(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_s) begin lat = i; break; end
    end
  endtask

  task automatic wait_done_k(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (done_k) begin lat = i; break; end
    end
  endtask

  int glat, lat, gk_seen, ds_before;
  logic [7:0] sref;

  initial begin
    rst = 1'b1; req_s = 1'b0; req_k = 1'b0; din_s = '0; din_k = '0;
    tick();
    tick();

    // reset values while rst is held
    check("rst_busy",   busy,      1'b0);
    check("rst_gnt_s",  gnt_s,     1'b0);
    check("rst_gnt_k",  gnt_k,     1'b0);
    check("rst_done_s", done_s,    1'b0);
    check("rst_done_k", done_k,    1'b0);
    check("rst_res_s",  res_s,     128'h0);
    check("rst_res_k",  res_k,     32'h0);
    check("rst_state",  dbg_state, 2'd0);
    rst = 1'b0;
    tick();

    // single S job
    start_s(A_DIN, glat);
    check("s_gnt_lat", glat, 1);
    check("s_busy_run", busy, 1'b1);
    wait_done_s(lat);
    check("s_done_lat", lat, 16);
    check("s_res", res_s, A_RES);
    check("s_busy_at_done", busy, 1'b0);
    tick();
    check("s_done_pulse", done_s, 1'b0);

    // single K job; res_s must stay put
    start_k(B_DIN, glat);
    check("k_gnt_lat", glat, 1);
    wait_done_k(lat);
    check("k_done_lat", lat, 4);
    check("k_res", res_k, B_RES);
    check("k_res_s_hold", res_s, A_RES);
    tick();

    // req_k toggled during RUN_S is ignored; partial bytes visible mid-job
    start_s(128'h0, glat);
    gk_seen = 0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 4) check("s_partial", res_s, 128'h63636363_1bfc33f5_c4eeacea_4bc12816);
      req_k = (i >= 2 && i <= 10 && (i % 2 == 0));
      if (gnt_k) gk_seen++;
      if (done_s) begin lat = i; break; end
    end
    req_k = 1'b0;
    check("s2_done_lat", lat, 16);
    check("s2_no_gnt_k", gk_seen, 0);
    check("s2_res", res_s, {16{8'h63}});
    tick();
    check("s2_idle_no_gnt_k", gnt_k, 1'b0);

    // din_k changing during RUN_K has no effect
    start_k(B_DIN, glat);
    din_k = 32'hffffffff;
    wait_done_k(lat);
    check("k2_done_lat", lat, 4);
    check("k2_res", res_k, B_RES);
    tick();

    // tie arbitration from a fresh reset: S first, then K on the next tie
    do_reset();
    req_s = 1'b1; din_s = A_DIN;
    req_k = 1'b1; din_k = B_DIN;
    tick();
    check("tie1_gnt_s", gnt_s, 1'b1);
    check("tie1_gnt_k", gnt_k, 1'b0);
    wait_done_s(lat);
    check("tie1_done_lat", lat, 16);
    tick();
    check("tie2_gnt_k", gnt_k, 1'b1);
    check("tie2_gnt_s", gnt_s, 1'b0);
    req_k = 1'b0;
    wait_done_k(lat);
    check("tie2_done_lat", lat, 4);
    check("tie2_res_k", res_k, B_RES);
    tick();
    check("tie3_gnt_s", gnt_s, 1'b1);
    req_s = 1'b0;
    wait_done_s(lat);
    check("tie3_done_lat", lat, 16);
    check("tie3_res_s", res_s, A_RES);
    tick();

    // reset at idx=7 of an S job, K request held across reset release
    start_s(128'hffeeddccbbaa99887766554433221100, glat);
    for (int i = 0; i < 7; i++) tick();
    ds_before = done_s_total;
    rst = 1'b1;
    #1;
    check("abort_res_s", res_s, 128'h0);
    check("abort_busy", busy, 1'b0);
    check("abort_res_k", res_k, 32'h0);
    req_k = 1'b1; din_k = B_DIN;
    tick();
    rst = 1'b0;
    tick();
    check("rel_gnt_k", gnt_k, 1'b1);
    req_k = 1'b0;
    wait_done_k(lat);
    check("rel_done_lat", lat, 4);
    check("rel_res_k", res_k, B_RES);
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_done_s", done_s_total - ds_before, 0);
    start_s(A_DIN, glat);
    wait_done_s(lat);
    check("post_abort_lat", lat, 16);
    check("post_abort_res", res_s, A_RES);
    tick();

    // S-box sweep through the K path
    for (int n = 0; n < 256; n++) begin
      sref = sbox_ref(8'(n));
      start_k({4{8'(n)}}, glat);
      wait_done_k(lat);
      check($sformatf("sweep_%0h", n), res_k, {4{sref}});
    end

    check("pulse_exclusive", excl_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sub_bytes_sched.md
SUB_BYTES_SCHED -- requirements
Module: sub_bytes_sched

Interface
REQ-001 Parameters: none; all widths fixed by AES (128-bit state, 32-bit word, 8-bit S-box byte).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_s  input  1  state requester: SubBytes job pending (level).
REQ-005 din_s  input  128  state to substitute; byte 0 = bits [127:120].
REQ-006 req_k  input  1  key-schedule requester: SubWord job pending (level).
REQ-007 din_k  input  32  key word to substitute; byte 0 = bits [31:24].
REQ-008 gnt_s / gnt_k  output  1 each  one-cycle grant pulse; input data was captured.
REQ-009 done_s / done_k  output  1 each  one-cycle completion pulse.
REQ-010 res_s  output  128  SubBytes result; res_k  output  32  SubWord result.
REQ-011 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-012 One shared combinational S-box instance; exactly one byte substituted per cycle.
REQ-013 FSM states IDLE, RUN_S, RUN_K; byte counter idx 4 bits.
REQ-014 IDLE, one request high: at the edge, capture its din, idx<=0, move to RUN_S/RUN_K.
REQ-015 IDLE, both requests high: grant the requester not served last; last_grant resets to K, so S wins the first tie.
REQ-016 gnt_x high for exactly the first cycle after the capture edge.
REQ-017 RUN_S: each edge writes S-box(byte idx) into res_s byte idx and increments idx; after byte 15: IDLE, done_s high the next cycle.
REQ-018 RUN_K: same over 4 bytes into res_k; after byte 3: IDLE, done_k high the next cycle.
REQ-019 Latency: done_s 16 cycles after capture edge; done_k 4 cycles after capture edge.
REQ-020 Requests and din ignored while busy; no queueing, no preemption.
REQ-021 Requester holds req and din stable until gnt, then drops req within the job duration; a still-high req at return to IDLE is granted again.
REQ-022 Back-to-back: the cycle done_x is high is an IDLE cycle, and a grant decision may occur on it (zero bubble beyond it).
REQ-023 res_s / res_k hold their last completed value until overwritten by the next job of that type; partially written bytes are visible during RUN.
REQ-024 done_s and done_k never high in the same cycle; gnt_s and gnt_k never high in the same cycle.

Reset
REQ-025 On rst: FSM to IDLE, idx 0, last_grant K, busy 0, gnt_s/gnt_k/done_s/done_k 0, res_s 0, res_k 0.
REQ-026 Reset mid-job aborts the job; no done pulse follows; results cleared.
REQ-027 A request held across reset release is granted on the first edge after release.

Structure
REQ-028 Shared package holds FSM state encoding, last-grant encoding, byte/word/state width constants and job lengths (16, 4).
REQ-029 One sub-module: the existing sbox (ports a, c) instantiated once; arbitration, FSM and result registers stay in sub_bytes_sched.

Verification
REQ-030 req_s with din_s=00112233445566778899aabbccddeeff -> gnt_s next cycle, done_s 16 cycles after capture, res_s=638293c31bfc33f5c4eeacea4bc12816.
REQ-031 req_k with din_k=09cf4f3c -> done_k 4 cycles after capture, res_k=018a84eb, res_s unchanged.
REQ-032 req_s and req_k raised together after reset, both held until granted -> S served first, K granted the cycle done_s is high; on the next tie, K wins.
REQ-033 rst pulsed at idx=7 of an S job -> no done_s, res_s=0, busy=0; a new job completes correctly.
REQ-034 req_k toggled during RUN_S -> ignored until IDLE; din_k changes during RUN_K do not affect res_k.
REQ-035 Sweep all 256 byte values through the K path (din_k bytes n,n,n,n) -> each result byte equals the FIPS-197 S-box entry.
